exec_unit_mc: RTL

//  Parametrised multi-cycle execute stage: register file plus single-cycle ALU path plus iterative MULT/DIV unit with HI/LO.

---
 rtl/exec_pkg.sv | 114 +++++++++++
 rtl/muldiv_iter.sv | 116 +++++++++++
 rtl/exec_unit_mc.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared constants, types and decoder for the multi-cycle execute stage.
// Covers the MIPS integer ALU subset plus MULT/DIV and HI/LO moves.
package exec_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic {
    S_IDLE,
    S_MD_RUN
  } state_t;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_AND, A_OR,
    A_XOR, A_NOR, A_SLT, A_SLTU,
    A_SLL, A_SRL, A_SRA, A_LUI,
    A_HI, A_LO
  } alu_op_t;

  typedef struct packed {
    logic    wr;
    logic    md;
    logic    use_imm;
    logic    sext;
    logic    var_sh;
    logic    rt_dst;
    alu_op_t op;
  } dec_t;

  function automatic dec_t decode_instr(input logic [31:0] ins);
    dec_t d;
    d.wr      = 1'b0;
    d.md      = 1'b0;
    d.use_imm = 1'b0;
    d.sext    = 1'b0;
    d.var_sh  = 1'b0;
    d.rt_dst  = 1'b0;
    d.op      = A_ADD;
    if (ins[31:26] == OP_RTYPE) begin
      d.wr = 1'b1;
      case (ins[5:0])
        F_SLL:  d.op = A_SLL;
        F_SRL:  d.op = A_SRL;
        F_SRA:  d.op = A_SRA;
        F_SLLV: begin d.op = A_SLL; d.var_sh = 1'b1; end
        F_SRLV: begin d.op = A_SRL; d.var_sh = 1'b1; end
        F_SRAV: begin d.op = A_SRA; d.var_sh = 1'b1; end
        F_MFHI: d.op = A_HI;
        F_MFLO: d.op = A_LO;
        F_ADD, F_ADDU: d.op = A_ADD;
        F_SUB, F_SUBU: d.op = A_SUB;
        F_AND:  d.op = A_AND;
        F_OR:   d.op = A_OR;
        F_XOR:  d.op = A_XOR;
        F_NOR:  d.op = A_NOR;
        F_SLT:  d.op = A_SLT;
        F_SLTU: d.op = A_SLTU;
        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
          d.wr = 1'b0;
          d.md = 1'b1;
        end
        default: d.wr = 1'b0;
      endcase
    end else begin
      d.wr      = 1'b1;
      d.use_imm = 1'b1;
      d.rt_dst  = 1'b1;
      case (ins[31:26])
        OP_ADDI, OP_ADDIU: begin d.op = A_ADD; d.sext = 1'b1; end
        OP_SLTI:  begin d.op = A_SLT;  d.sext = 1'b1; end
        OP_SLTIU: begin d.op = A_SLTU; d.sext = 1'b1; end
        OP_ANDI:  d.op = A_AND;
        OP_ORI:   d.op = A_OR;
        OP_XORI:  d.op = A_XOR;
        OP_LUI:   d.op = A_LUI;
        default:  d.wr = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// op[1] selects divide, op[0] selects unsigned; results are valid with done.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              dz
);

  localparam int CW = $clog2(DATA_W);

  logic              run;
  logic [CW-1:0]     cnt;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              bz;
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] mq;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] a_raw;

  logic              sa;
  logic              sb;
  logic [DATA_W-1:0] ma;
  logic [DATA_W-1:0] mb;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     shf;
  logic [DATA_W:0]     dif;
  logic [DATA_W:0]     pick;
  logic [DATA_W:0]     acc_nx;
  logic [DATA_W-1:0]   mq_nx;
  logic [2*DATA_W-1:0] prod;

  assign sa = ~op[0] & a[DATA_W-1];
  assign sb = ~op[0] & b[DATA_W-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  always_comb begin
    sum  = acc + {1'b0, dvs};
    shf  = {acc[DATA_W-1:0], mq[DATA_W-1]};
    dif  = shf - {1'b0, dvs};
    pick = mq[0] ? sum : acc;
    if (is_div) begin
      acc_nx = dif[DATA_W] ? shf : dif;
      mq_nx  = {mq[DATA_W-2:0], ~dif[DATA_W]};
    end else begin
      acc_nx = {1'b0, pick[DATA_W:1]};
      mq_nx  = {pick[0], mq[DATA_W-1:1]};
    end
  end

  // Final step result with sign fix, presented on the completing cycle
  always_comb begin
    prod = {acc_nx[DATA_W-1:0], mq_nx};
    if (neg_q) prod = -prod;
    if (is_div) begin
      lo = neg_q ? -mq_nx : mq_nx;
      hi = neg_r ? -acc_nx[DATA_W-1:0] : acc_nx[DATA_W-1:0];
      if (bz) begin
        lo = '1;
        hi = a_raw;
      end
    end else begin
      hi = prod[2*DATA_W-1:DATA_W];
      lo = prod[DATA_W-1:0];
    end
  end

  assign done = run && (cnt == '0);
  assign dz   = done && is_div && bz;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      bz     <= 1'b0;
      acc    <= '0;
      mq     <= '0;
      dvs    <= '0;
      a_raw  <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= CW'(DATA_W - 1);
      is_div <= op[1];
      neg_q  <= sa ^ sb;
      neg_r  <= op[1] & sa;
      bz     <= (b == '0);
      acc    <= '0;
      mq     <= ma;
      dvs    <= mb;
      a_raw  <= a;
    end else if (run) begin
      acc <= acc_nx;
      mq  <= mq_nx;
      cnt <= cnt - 1'b1;
      if (cnt == '0) run <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Execute stage: register file, single-cycle ALU and iterative mul/div.
// Upstream is stalled via in_ready while the mul/div unit iterates.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div0,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  state_t state;
  state_t nstate;
  dec_t   d;

  logic [DATA_W-1:0] regs [NREGS];

  logic [AW-1:0]     rs_a;
  logic [AW-1:0]     rt_a;
  logic [AW-1:0]     dst;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] b_op;
  logic [4:0]        sh;
  logic [DATA_W-1:0] res;

  logic              go;
  logic              md_start;
  logic              wr_go;
  logic              md_done;
  logic              md_dz;
  logic [DATA_W-1:0] md_hi;
  logic [DATA_W-1:0] md_lo;

  assign d      = decode_instr(instr);
  assign rs_a   = instr[21 +: AW];
  assign rt_a   = instr[16 +: AW];
  assign dst    = d.rt_dst ? rt_a : instr[11 +: AW];
  assign rs_val = regs[rs_a];
  assign rt_val = regs[rt_a];

  assign imm_ext = d.sext
    ? {{(DATA_W-16){instr[15]}}, instr[15:0]}
    : {{(DATA_W-16){1'b0}}, instr[15:0]};
  assign b_op = d.use_imm ? imm_ext : rt_val;
  assign sh   = d.var_sh ? rs_val[4:0] : instr[10:6];

  always_comb begin
    res = '0;
    case (d.op)
      A_ADD:  res = rs_val + b_op;
      A_SUB:  res = rs_val - b_op;
      A_AND:  res = rs_val & b_op;
      A_OR:   res = rs_val | b_op;
      A_XOR:  res = rs_val ^ b_op;
      A_NOR:  res = ~(rs_val | b_op);
      A_SLT:  res = {{(DATA_W-1){1'b0}},
                     $signed(rs_val) < $signed(b_op)};
      A_SLTU: res = {{(DATA_W-1){1'b0}}, rs_val < b_op};
      A_SLL:  res = rt_val << sh;
      A_SRL:  res = rt_val >> sh;
      A_SRA:  res = $signed(rt_val) >>> sh;
      A_LUI:  res = {instr[15:0], {(DATA_W-16){1'b0}}};
      A_HI:   res = hi;
      A_LO:   res = lo;
      default: res = '0;
    endcase
  end

  assign go       = in_valid && in_ready;
  assign md_start = go && d.md;
  assign wr_go    = go && d.wr && (dst != '0);

  muldiv_iter #(.DATA_W(DATA_W)) u_md (
    .CLK   (CLK),
    .rst   (rst),
    .start (md_start),
    .op    (instr[1:0]),
    .a     (rs_val),
    .b     (rt_val),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo),
    .dz    (md_dz)
  );

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   if (md_start) nstate = S_MD_RUN;
      S_MD_RUN: if (md_done)  nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  // in_ready is gated by reset so upstream never sees it during reset
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      S_IDLE:   in_ready = rst;
      S_MD_RUN: busy     = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= wr_go;
      if (wr_go) begin
        regs[dst] <= res;
        wb_addr   <= dst;
        wb_data   <= res;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      hi   <= '0;
      lo   <= '0;
      div0 <= 1'b0;
    end else if (md_done) begin
      hi <= md_hi;
      lo <= md_lo;
      if (md_dz) div0 <= 1'b1;
    end
  end

  assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];

endmodule
